// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity-mode constants and FSM state encoding
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5,
        ST_BREAK  = 3'd6
    } uart_state_e;

endpackage

// File: rtl/uart_baud_timer.sv
// rtl/uart_baud_timer.sv - bit-period timer with half-bit and terminal-count ticks
module uart_baud_timer #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half_tick,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign half_tick = (count_q == CNT_W'(CLK_PER_BIT / 2));
    assign bit_tick  = (count_q == CNT_W'(CLK_PER_BIT - 1));

    // Count 0..CLK_PER_BIT-1 and wrap at terminal count; clear forces zero.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || bit_tick) begin
            count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised RS232 receiver with valid/ack output register
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 1);

    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 timer_clear;
    logic                 half_tick, bit_tick;
    logic                 load;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 overrun_q, overrun_d;

    assign rx_s        = sync2_q;
    assign busy        = (state_q != ST_IDLE);
    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_out_q;
    assign frame_err   = ferr_out_q;
    assign overrun_err = overrun_q;

    uart_baud_timer #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .half_tick(half_tick),
        .bit_tick (bit_tick)
    );

    // Frame FSM: start validation at half bit, then one sample per bit period.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        timer_clear = 1'b0;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    timer_clear = 1'b1;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    perr_d  = (^shift_q) ^ rx_s ^ (PARITY_MODE == PAR_ODD);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_DONE: begin
                load    = 1'b1;
                state_d = rx_s ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register: load beats ack; load over an unacked word flags overrun.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = overrun_q;
        if (load) begin
            data_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_q;
            valid_d    = 1'b1;
            if (valid_q && !rx_ack) begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // Synchroniser, FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Host-facing output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule
